elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
Three-floor elevator controller FSM. It latches hall-call and car-call buttons into request lamps and moves the car one floor at a time using a direction-preserving (SCAN) policy. It opens the door at each requested floor and clears the serviced lamps. It sits between the button/lamp I/O and the car drive/door actuators.

Parameters:
TRAVEL_CYCLES, 4, clock cycles to move between adjacent floors (>=1)
DOOR_OPEN_CYCLES, 4, clock cycles the door stays open per stop (>=1)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  reset
elevator_floor_button_pressed  in  3  car buttons: [2]=floor1, [1]=floor2, [0]=floor3
floor_button_pressed  in  4  hall buttons: [3]=F1 up, [2]=F2 down, [1]=F2 up, [0]=F3 down
floor  out  3  one-hot car position: 100=F1, 010=F2, 001=F3
door  out  1  1=open, 0=closed
elevator_button_out  out  3  latched car-call lamps, same bit map as car buttons
floor_button_out  out  4  latched hall-call lamps, same bit map as hall buttons

Behaviour:
- Single clock clk; reset rst_n is synchronous and active-high.
- Reset values: floor=100 (F1), door=0, all lamps 0, state IDLE, direction UP, counters 0.
- Reset asserted mid-travel or with the door open returns immediately to the reset values. Pending requests are discarded.
- All outputs are registered.
- Request latching:
  - A button high at a rising edge sets its lamp bit at that edge (1-cycle latency). Pulses of 1 cycle are sufficient.
  - A lamp stays set until serviced. Re-pressing a lit button has no effect.
- Floor request: req(F) = car lamp for F OR any hall lamp at F. Requests above/below are evaluated against the current floor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE (door=0):
  - If req(current floor): go to DOOR_OPEN.
  - Else if requests exist in the stored direction: go to MOVE in that direction.
  - Else if requests exist in the opposite direction: flip the direction, then MOVE.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Count TRAVEL_CYCLES, then shift floor by one position (up: 100->010->001; down: reverse).
  - On arrival, if req(new floor): DOOR_OPEN.
  - Else if requests remain further in the same direction: keep moving.
  - Else: IDLE.
  - The car never moves beyond F1 or F3. At an end floor, the direction flips to face inward.
- DOOR_OPEN:
  - On entry: door=1, and the car lamp and all hall lamps of the current floor are cleared (at F2, both up and down).
  - Stay DOOR_OPEN_CYCLES cycles, then go to IDLE with door=0.
  - While the door is open, presses for the current floor are not latched.
- Simultaneous events:
  - A clear and a new press for the same bit in the same cycle: the clear wins.
  - Presses for other floors are always latched.
- Door is never 1 while in a MOVE state. floor changes only in MOVE states.

Optional Feature:
DOOR_REOPEN_EN.
- Defined: while in DOOR_OPEN, a press of any button belonging to the current floor restarts the door counter (door held open a further DOOR_OPEN_CYCLES). The lamp still stays 0.
- Undefined: such presses are ignored and the door closes on schedule.

Test Plan:
- Reset for 5 cycles, then idle: floor=100, door=0, elevator_button_out=000, floor_button_out=0000, unchanged over 20 cycles.
- Pulse floor_button_pressed[0] for 1 cycle at F1 (edge E0), expected responses:
  - floor_button_out=0001 after E0.
  - floor=010 after E0+5.
  - floor=001, door=1, floor_button_out=0000 after E0+9.
  - door=0 after E0+13.
- At F3, pulse elevator_floor_button_pressed[2] -> lamp 100 set; floor passes 010, reaches 100; door opens and lamp clears. No stop at F2.
- At F1, pulse floor_button_pressed[2:1]=11, then later elevator_floor_button_pressed[1:0]=11 -> car stops at F2 (clears 0110 and car bit 010), then continues up to F3 (clears car bit 001).
- While moving up from F1 to F3, pulse elevator_floor_button_pressed[2] -> no reversal; F3 serviced first, then the car returns to F1.
- Press the current floor's button while the door is open:
  - Lamp stays 0.
  - Door closes after DOOR_OPEN_CYCLES, or is extended if DOOR_REOPEN_EN is defined.
- Assert rst_n for 1 cycle mid-travel -> floor=100, door=0, all lamps 0 on the next edge.

Source files
------------

// File: rtl/elevator_ctrl_if.sv
// elevator_ctrl_if: button inputs and lamp/car/door outputs of the elevator controller
interface elevator_ctrl_if;
  logic [2:0] elevator_floor_button_pressed;
  logic [3:0] floor_button_pressed;
  logic [2:0] floor;
  logic       door;
  logic [2:0] elevator_button_out;
  logic [3:0] floor_button_out;
  modport master (
    output elevator_floor_button_pressed, floor_button_pressed,
    input  floor, door, elevator_button_out, floor_button_out
  );
  modport slave (
    input  elevator_floor_button_pressed, floor_button_pressed,
    output floor, door, elevator_button_out, floor_button_out
  );
endinterface

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: three-floor SCAN elevator FSM with latched call lamps; DOOR_REOPEN_EN lets a
// press at the current floor restart the door timer.
module elevator_ctrl #(
  parameter int TRAVEL_CYCLES    = 4,
  parameter int DOOR_OPEN_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  elevator_ctrl_if.slave io
);
  localparam int MAXC = TRAVEL_CYCLES > DOOR_OPEN_CYCLES ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  state_t state;
  logic up;
  logic [CW-1:0] cnt;
  logic [2:0] reqv, step, at, clr;
  logic arrive, open_go, hit;
  // floors are one-hot with F1 in the MSB, so lower bit index means higher floor
  function automatic logic above(input logic [2:0] r, input logic [2:0] f);
    return |(r & (f - 3'd1));
  endfunction
  function automatic logic below(input logic [2:0] r, input logic [2:0] f);
    return |(r & ~(f | (f - 3'd1)));
  endfunction
  always_comb begin
    reqv = {io.elevator_button_out[2] | io.floor_button_out[3],
            io.elevator_button_out[1] | io.floor_button_out[2] | io.floor_button_out[1],
            io.elevator_button_out[0] | io.floor_button_out[0]};
    step = state == MOVE_UP ? io.floor >> 1 : io.floor << 1;
    arrive = (state == MOVE_UP || state == MOVE_DOWN) && cnt == CW'(TRAVEL_CYCLES - 1);
    at = arrive ? step : io.floor;
    open_go = (state == IDLE || arrive) && |(reqv & at);
    clr = (open_go || state == DOOR_OPEN) ? at : 3'b000;
`ifdef DOOR_REOPEN_EN
    hit = state == DOOR_OPEN &&
          (|(io.elevator_floor_button_pressed & io.floor) ||
           |(io.floor_button_pressed & {io.floor[2], io.floor[1], io.floor[1], io.floor[0]}));
`else
    hit = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      up <= 1'b1;
      cnt <= '0;
      io.floor <= 3'b100;
      io.door <= 1'b0;
      io.elevator_button_out <= 3'b000;
      io.floor_button_out <= 4'b0000;
    end else begin
      io.elevator_button_out <= (io.elevator_button_out | io.elevator_floor_button_pressed) & ~clr;
      io.floor_button_out <= (io.floor_button_out | io.floor_button_pressed) &
                             ~{clr[2], clr[1], clr[1], clr[0]};
      case (state)
        IDLE: begin
          cnt <= '0;
          if (open_go) begin
            state <= DOOR_OPEN;
            io.door <= 1'b1;
          end else if (up ? above(reqv, io.floor) : below(reqv, io.floor)) begin
            state <= up ? MOVE_UP : MOVE_DOWN;
          end else if (up ? below(reqv, io.floor) : above(reqv, io.floor)) begin
            up <= !up;
            state <= up ? MOVE_DOWN : MOVE_UP;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (!arrive) cnt <= cnt + 1'b1;
          else begin
            cnt <= '0;
            io.floor <= step;
            if (step[0]) up <= 1'b0;
            else if (step[2]) up <= 1'b1;
            if (open_go) begin
              state <= DOOR_OPEN;
              io.door <= 1'b1;
            end else if (!(state == MOVE_UP ? above(reqv, step) : below(reqv, step))) begin
              state <= IDLE;
            end
          end
        end
        DOOR_OPEN: begin
          if (hit) cnt <= '0;
          else if (cnt == CW'(DOOR_OPEN_CYCLES - 1)) begin
            cnt <= '0;
            state <= IDLE;
            io.door <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed checks of latching, SCAN travel, door timing and reset.
module tb_elevator_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  elevator_ctrl_if bus ();
  elevator_ctrl #(.TRAVEL_CYCLES(4), .DOOR_OPEN_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic all_is(input string tag, input logic [2:0] fl, input logic dr,
                        input logic [2:0] cl, input logic [3:0] hl);
    chk({tag, ".floor"}, 32'(bus.floor), 32'(fl));
    chk({tag, ".door"}, 32'(bus.door), 32'(dr));
    chk({tag, ".car"}, 32'(bus.elevator_button_out), 32'(cl));
    chk({tag, ".hall"}, 32'(bus.floor_button_out), 32'(hl));
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.elevator_floor_button_pressed = 3'b000;
    bus.floor_button_pressed = 4'b0000;
    step(5);
    rst_n = 1'b0;
    all_is("reset", 3'b100, 1'b0, 3'b000, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      step(1);
      all_is("idle", 3'b100, 1'b0, 3'b000, 4'b0000);
    end
    // F1 -> F3 on a hall call
    bus.floor_button_pressed = 4'b0001; step(1); bus.floor_button_pressed = 4'b0000;
    chk("a.lamp", 32'(bus.floor_button_out), 32'h1);
    step(4); chk("a.e4_floor", 32'(bus.floor), 32'h4); chk("a.e4_door", 32'(bus.door), 0);
    step(1); all_is("a.e5", 3'b010, 1'b0, 3'b000, 4'b0001);
    step(4); all_is("a.e9", 3'b001, 1'b1, 3'b000, 4'b0000);
    step(3); chk("a.e12_door", 32'(bus.door), 1);
    step(1); chk("a.e13_door", 32'(bus.door), 0); chk("a.e13_floor", 32'(bus.floor), 32'h1);
    // F3 -> F1 car call, no stop at F2
    bus.elevator_floor_button_pressed = 3'b100; step(1); bus.elevator_floor_button_pressed = 3'b000;
    chk("b.lamp", 32'(bus.elevator_button_out), 32'h4);
    step(5); all_is("b.e5", 3'b010, 1'b0, 3'b100, 4'b0000);
    step(1); chk("b.e6_floor", 32'(bus.floor), 32'h2); chk("b.e6_door", 32'(bus.door), 0);
    step(3); all_is("b.e9", 3'b100, 1'b1, 3'b000, 4'b0000);
    step(4); chk("b.e13_door", 32'(bus.door), 0);
    // moving up from F1, an F1 car call does not reverse the car
    bus.floor_button_pressed = 4'b0001; step(1); bus.floor_button_pressed = 4'b0000;
    chk("d.lamp", 32'(bus.floor_button_out), 32'h1);
    step(2);
    bus.elevator_floor_button_pressed = 3'b100; step(1); bus.elevator_floor_button_pressed = 3'b000;
    chk("d.e3_car", 32'(bus.elevator_button_out), 32'h4); chk("d.e3_floor", 32'(bus.floor), 32'h4);
    step(2); all_is("d.e5", 3'b010, 1'b0, 3'b100, 4'b0001);
    step(4); all_is("d.e9", 3'b001, 1'b1, 3'b100, 4'b0000);
    step(4); chk("d.e13_door", 32'(bus.door), 0);
    step(5); all_is("d.e18", 3'b010, 1'b0, 3'b100, 4'b0000);
    step(4); all_is("d.e22", 3'b100, 1'b1, 3'b000, 4'b0000);
    step(4); chk("d.e26_door", 32'(bus.door), 0);
    // stop at F2 for both hall calls and a car call, then on to F3
    bus.floor_button_pressed = 4'b0110; step(1); bus.floor_button_pressed = 4'b0000;
    chk("c.hall", 32'(bus.floor_button_out), 32'h6);
    step(1);
    bus.elevator_floor_button_pressed = 3'b011; step(1); bus.elevator_floor_button_pressed = 3'b000;
    chk("c.car", 32'(bus.elevator_button_out), 32'h3);
    step(3); all_is("c.e5", 3'b010, 1'b1, 3'b001, 4'b0000);
    step(4); chk("c.e9_door", 32'(bus.door), 0); chk("c.e9_floor", 32'(bus.floor), 32'h2);
    step(5); all_is("c.e14", 3'b001, 1'b1, 3'b000, 4'b0000);
    step(4); chk("c.e18_door", 32'(bus.door), 0);
    // press the current floor while the door is open
    bus.floor_button_pressed = 4'b0001; step(1); bus.floor_button_pressed = 4'b0000;
    chk("o.lamp", 32'(bus.floor_button_out), 32'h1); chk("o.e0_door", 32'(bus.door), 0);
    step(1); all_is("o.e1", 3'b001, 1'b1, 3'b000, 4'b0000);
    bus.elevator_floor_button_pressed = 3'b001; bus.floor_button_pressed = 4'b0001; step(1);
    bus.elevator_floor_button_pressed = 3'b000; bus.floor_button_pressed = 4'b0000;
    all_is("o.e2", 3'b001, 1'b1, 3'b000, 4'b0000);
    step(3);
`ifdef DOOR_REOPEN_EN
    chk("o.e5_door", 32'(bus.door), 1);
`else
    chk("o.e5_door", 32'(bus.door), 0);
`endif
    step(1); all_is("o.e6", 3'b001, 1'b0, 3'b000, 4'b0000);
    // reset mid-travel discards pending calls
    bus.elevator_floor_button_pressed = 3'b100; step(1); bus.elevator_floor_button_pressed = 3'b000;
    step(1);
    bus.floor_button_pressed = 4'b0010; step(1); bus.floor_button_pressed = 4'b0000;
    all_is("r.pre", 3'b001, 1'b0, 3'b100, 4'b0010);
    rst_n = 1'b1; step(1); rst_n = 1'b0;
    all_is("r.post", 3'b100, 1'b0, 3'b000, 4'b0000);
    step(10); all_is("r.settle", 3'b100, 1'b0, 3'b000, 4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
